// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin scheduler feeding a MSB-first parallel-in/serial-out shifter.
// Emits framing strobes alongside each serial bit.
module piso_tx_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] pi0,
    input  logic             req1,
    input  logic [WIDTH-1:0] pi1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last,
    output logic             busy,
    output logic             owner
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;
    logic             pref_reg;
    logic             owner_reg;
    logic             gnt0_reg;
    logic             gnt1_reg;

    logic             at_last;
    logic             load_opp;
    logic             any_req;
    logic             win1;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shift_word;

    assign at_last  = (state_reg == SHIFT) && (cnt_reg == LAST);
    assign load_opp = (state_reg == IDLE) || at_last;
    assign any_req  = req0 | req1;
    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign win1     = req1 & (~req0 | pref_reg);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            assign load_word[gi] = win1 ? pi1[gi] : pi0[gi];
            if (gi == 0) begin : g_lsb
                assign shift_word[gi] = 1'b0;
            end else begin : g_upper
                assign shift_word[gi] = shreg_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            pref_reg  <= 1'b0;
            owner_reg <= 1'b0;
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
        end else begin
            gnt0_reg <= 1'b0;
            gnt1_reg <= 1'b0;
            if (load_opp && any_req) begin
                state_reg <= SHIFT;
                shreg_reg <= load_word;
                cnt_reg   <= '0;
                owner_reg <= win1;
                pref_reg  <= ~win1;
                gnt0_reg  <= ~win1;
                gnt1_reg  <= win1;
            end else if (state_reg == SHIFT) begin
                shreg_reg <= shift_word;
                if (at_last) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    owner_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign so       = shreg_reg[WIDTH-1] & busy;
    assign so_valid = busy;
    assign so_first = busy & (cnt_reg == '0);
    assign so_last  = busy & (cnt_reg == LAST);
    assign owner    = owner_reg;
    assign gnt0     = gnt0_reg;
    assign gnt1     = gnt1_reg;
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter (WIDTH=4): hand-computed serial streams, grants and strobes.
module tb_piso_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] pi0, pi1;
    logic       gnt0, gnt1, so, so_valid, so_first, so_last, busy, owner;
    logic [7:0] outs;

    int vectors    = 0;
    int miscompares = 0;

    piso_tx_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .pi0(pi0), .req1(req1), .pi1(pi1),
        .gnt0(gnt0), .gnt1(gnt1), .so(so), .so_valid(so_valid),
        .so_first(so_first), .so_last(so_last), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    assign outs = {gnt0, gnt1, so, so_valid, so_first, so_last, busy, owner};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected output vector: {gnt0,gnt1,so,so_valid,so_first,so_last,busy,owner}
    function automatic logic [7:0] frame_bit(input logic g0, input logic g1, input logic b,
                                             input int idx, input logic own);
        return {g0, g1, b, 1'b1, (idx == 0), (idx == 3), 1'b1, own};
    endfunction

    initial begin
        logic [7:0] stream;
        logic [3:0] word;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; pi0 = 4'h0; pi1 = 4'h0;
        #1;
        check("reset_outs", outs, 8'h00);
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("idle_no_req", outs, 8'h00);
        end

        // Single word from requester 0
        req0 = 1'b1; pi0 = 4'b1010;
        word = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("single_bit%0d", i), outs,
                  frame_bit(i == 0, 1'b0, word[3-i], i, 1'b0));
            req0 = 1'b0;
        end
        tick;
        check("single_idle", outs, 8'h00);

        // Asynchronous reset mid-cycle; also restores pref to requester 0
        #2 rst = 1'b1;
        #1 check("async_rst_idle", outs, 8'h00);
        #1 rst = 1'b0;

        // Contention: both raised together, requester 0 first
        req0 = 1'b1; pi0 = 4'b1010; req1 = 1'b1; pi1 = 4'b1101;
        stream = 8'b1010_1101;
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("contend_bit%0d", i), outs,
                  frame_bit(i == 0, i == 4, stream[7-i], i % 4, i >= 4));
            if (i == 0) req0 = 1'b0;
            if (i == 4) req1 = 1'b0;
        end
        tick;
        check("contend_idle", outs, 8'h00);

        // Fairness: both held continuously, grants alternate 0,1,0,1 with no gap
        req0 = 1'b1; req1 = 1'b1; pi0 = 4'b1001; pi1 = 4'b0111;
        for (int i = 0; i < 16; i++) begin
            tick;
            word = ((i / 4) % 2 == 0) ? 4'b1001 : 4'b0111;
            check($sformatf("fair_bit%0d", i), outs,
                  frame_bit(i % 8 == 0, i % 8 == 4, word[3 - (i % 4)], i % 4, (i / 4) % 2 == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;
        check("fair_idle", outs, 8'h00);

        // Mid-frame request waits for the last bit of the running frame
        req0 = 1'b1; pi0 = 4'b1010;
        stream = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("midreq_bit%0d", i), outs,
                  frame_bit(i == 0, i == 4, stream[7-i], i % 4, i >= 4));
            if (i == 0) req0 = 1'b0;
            if (i == 1) begin req1 = 1'b1; pi1 = 4'b0110; end
            if (i == 4) req1 = 1'b0;
        end
        tick;
        check("midreq_idle", outs, 8'h00);

        // Reset during bit 3 aborts the frame; pref returns to requester 0
        req1 = 1'b1; pi1 = 4'b1101;
        tick;
        check("rstmid_bit0", outs, frame_bit(1'b0, 1'b1, 1'b1, 0, 1'b1));
        req1 = 1'b0;
        tick;
        check("rstmid_bit1", outs, frame_bit(1'b0, 1'b0, 1'b1, 1, 1'b1));
        req1 = 1'b1; pi1 = 4'b0011;
        tick;
        check("rstmid_bit2", outs, frame_bit(1'b0, 1'b0, 1'b0, 2, 1'b1));
        #2 rst = 1'b1;
        #1 check("rstmid_abort", outs, 8'h00);
        req0 = 1'b1; pi0 = 4'b1100;
        #1 rst = 1'b0;
        stream = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            tick;
            check($sformatf("rstmid_after%0d", i), outs,
                  frame_bit(i == 0, i == 4, stream[7-i], i % 4, i >= 4));
            if (i == 0) req0 = 1'b0;
            if (i == 4) req1 = 1'b0;
        end
        tick;
        check("rstmid_idle", outs, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Two-requester serial transmit scheduler around a parallel-in/serial-out shifter. It arbitrates round-robin between two parallel-word sources and loads the winning word into an internal WIDTH-bit shift register. It then shifts the word out MSB-first, one bit per clock, with framing strobes. It sits between word-producing logic and a single shared serial line, replacing direct `load` control of a bare PISO.

## Interface
- `WIDTH`, default 4: word width and bits per frame (≥2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 has a word pending; held until `gnt0` is seen.
- `pi0`  in  WIDTH  requester 0 word; stable while `req0`=1.
- `req1`  in  1  requester 1 has a word pending; held until `gnt1` is seen.
- `pi1`  in  WIDTH  requester 1 word; stable while `req1`=1.
- `gnt0`  out  1  one-cycle pulse: requester 0 word accepted.
- `gnt1`  out  1  one-cycle pulse: requester 1 word accepted.
- `so`  out  1  serial data, MSB first; 0 when `so_valid`=0.
- `so_valid`  out  1  `so` carries a frame bit this cycle.
- `so_first`  out  1  current bit is the MSB of a frame.
- `so_last`  out  1  current bit is the LSB of a frame.
- `busy`  out  1  frame in progress (state SHIFT).
- `owner`  out  1  source of the current frame (0/1); 0 when idle.

## Operation
- Registers: `state` (IDLE, SHIFT), `shreg[WIDTH-1:0]`, `cnt` (bit index 0..WIDTH-1), `pref` (round-robin pointer), `owner`, `gnt0`, `gnt1`.
- Arbitration applies at any load opportunity: in IDLE, or in SHIFT while `cnt`==WIDTH-1.
  - Only one request: that requester wins.
  - Both requests: the requester indicated by `pref` wins.
  - After a grant to requester x, `pref` becomes the other requester.
- Load at edge: `shreg` ← winning word, `cnt` ← 0, `state` ← SHIFT, `owner` ← x, `gnt_x` ← 1 for exactly the next cycle.
- SHIFT, `cnt` < WIDTH-1: at each edge, `shreg` shifts left one bit (0 in) and `cnt` increments.
- SHIFT, `cnt`==WIDTH-1, no request: next state IDLE, `owner` ← 0.
- Outputs are derived from registers only:
  - `so` = `shreg[WIDTH-1]` & `busy`.
  - `so_valid` = `busy`.
  - `so_first` = `busy` & (`cnt`==0).
  - `so_last` = `busy` & (`cnt`==WIDTH-1).
- A requester still holding `req` during its own `gnt` cycle is never granted again for the same word. The next load opportunity is at least WIDTH-1 cycles later, and the requester drops `req` after seeing `gnt`.
- Frames are never truncated or preempted. A request arriving mid-frame waits for the last bit.
- Reset (asynchronous, any time including mid-frame): state IDLE, `shreg`=0, `cnt`=0, `pref`=0 (requester 0 preferred), `owner`=0, `gnt0`=`gnt1`=0. All outputs are 0 immediately, and the aborted frame is discarded.

## Timing
- Latency: request sampled at edge E → `gnt` and the MSB on `so` (`so_first`=1) in the cycle after E.
- Each frame occupies exactly WIDTH consecutive `so_valid` cycles; `gnt` coincides with the first.
- Back-to-back: a request pending at the edge ending the `so_last` cycle starts the next frame with zero gap.
- From IDLE, throughput is one frame per WIDTH cycles plus one cycle of request-to-grant latency.
- `gnt0` and `gnt1` are never both 1, and `gnt` never asserts outside the first bit of a frame.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 at once; after release with no requests, `busy`=0 indefinitely.
- Single word: `req0`=1, `pi0`=4'b1010 → `gnt0` pulse; `so`=1,0,1,0 over 4 cycles with `so_first` on bit 1 and `so_last` on bit 4; then IDLE.
- Contention: `req0` (1010) and `req1` (1101) raised together from reset, each dropped after its `gnt` → `so`=1,0,1,0,1,1,0,1. That is 8 consecutive valid cycles, with `owner` 0 then 1 and `gnt1` on cycle 5.
- Fairness: both requests held continuously and re-armed after each grant → grants alternate 0,1,0,1 and frames abut with no gap.
- Mid-frame request: `req1` raised during bit 2 of a `req0` frame → `gnt1` only with the first bit after the `so_last` cycle, and no bit of the first frame is altered.
- Reset mid-frame: `rst` pulsed during bit 3 → `so_valid` drops at once; after release, the still-pending `req1` is granted before `req0` only if `req0` is absent (`pref`=0 restored).
